branch_resolve_unit: RTL and testbench

//  EX-stage branch resolver: writer side of the fetch-stage branch-history table (BHT) protocol.

---
 rtl/branch_resolve_unit.sv | 141 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//   EX-stage branch resolver and writer side of the fetch-stage BHT protocol.
//   It computes the real outcome of each conditional branch and compares the
//   resulting next PC with the one fetch predicted. A mismatch raises a
//   one-cycle redirect/flush. Every resolved branch is queued as a BHT update
//   record and drained to the BHT write port over valid/ready.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ex_valid..ex_pred_pc EX-slot branch information (type, PC, offset, flags,
//                        predicted next PC)
//   stall_req           comb: branch in EX cannot resolve (update queue full)
//   redirect_valid/pc   registered mispredict pulse and correct next PC
//   flush               same as redirect_valid
//   upd_valid/ready     update-record handshake; upd_pc/taken/target = head
//   br_count            resolved branches (saturating)
//   mispred_count       mispredicted branches (saturating)
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int PC_W       = 30,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [2:0]       ex_type,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [15:0]      ex_imm,
    input  logic             ex_eq,
    input  logic             ex_neg,
    input  logic             ex_zero,
    input  logic [PC_W-1:0]  ex_pred_pc,
    output logic             stall_req,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [PC_W-1:0]  upd_pc,
    output logic             upd_taken,
    output logic [PC_W-1:0]  upd_target,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [PC_W-1:0] q_pc     [FIFO_DEPTH];
    logic            q_taken  [FIFO_DEPTH];
    logic [PC_W-1:0] q_target [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    logic            is_br;
    logic            taken;
    logic [PC_W-1:0] fall_pc;
    logic [PC_W-1:0] tgt_pc;
    logic [PC_W-1:0] actual_pc;
    logic            mispred;
    logic            pop;
    logic            push_ok;
    logic            resolve;

    always_comb begin
        taken = 1'b0;
        case (ex_type)
            3'b001:  taken = ex_eq;
            3'b010:  taken = ~ex_eq;
            3'b011:  taken = ~ex_neg;
            3'b100:  taken = ~ex_neg & ~ex_zero;
            3'b101:  taken = ex_neg | ex_zero;
            3'b110:  taken = ex_neg;
            default: taken = 1'b0;
        endcase
    end

    // The instruction in EX during a redirect cycle is wrong-path: ignore it.
    assign is_br     = ex_valid & (ex_type != 3'b000) & (ex_type != 3'b111) & ~redirect_valid;
    assign fall_pc   = ex_pc + PC_W'(1);
    assign tgt_pc    = fall_pc + {{(PC_W-16){ex_imm[15]}}, ex_imm};
    assign actual_pc = taken ? tgt_pc : fall_pc;
    assign mispred   = (actual_pc != ex_pred_pc);

    assign upd_valid = (count != '0);
    assign pop       = upd_valid & upd_ready;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign push_ok   = (count != FULL_CNT) | pop;
    assign resolve   = is_br & push_ok;
    assign stall_req = is_br & ~push_ok;

    assign flush      = redirect_valid;
    assign upd_pc     = upd_valid ? q_pc[rd_ptr]     : '0;
    assign upd_taken  = upd_valid ? q_taken[rd_ptr]  : 1'b0;
    assign upd_target = upd_valid ? q_target[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst && resolve) begin
            q_pc[wr_ptr]     <= ex_pc;
            q_taken[wr_ptr]  <= taken;
            q_target[wr_ptr] <= actual_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            br_count       <= '0;
            mispred_count  <= '0;
        end else begin
            redirect_valid <= resolve & mispred;
            if (resolve & mispred) begin
                redirect_pc <= actual_pc;
            end
            if (resolve) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({resolve, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (resolve && (br_count != '1)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (resolve && mispred && (mispred_count != '1)) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    typedef struct packed {
        logic [29:0] pc;
        logic        taken;
        logic [29:0] target;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  ex_type;
    logic [29:0] ex_pc;
    logic [15:0] ex_imm;
    logic        ex_eq, ex_neg, ex_zero;
    logic [29:0] ex_pred_pc;
    logic        stall_req;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        flush;
    logic        upd_valid;
    logic        upd_ready;
    logic [29:0] upd_pc;
    logic        upd_taken;
    logic [29:0] upd_target;
    logic [15:0] br_count;
    logic [15:0] mispred_count;

    branch_resolve_unit #(.PC_W(30), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_type(ex_type), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_eq(ex_eq), .ex_neg(ex_neg), .ex_zero(ex_zero), .ex_pred_pc(ex_pred_pc),
        .stall_req(stall_req), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    rec_t sbq[$];
    bit   pend;
    bit   pend_mis;
    rec_t pend_rec;
    bit   exp_rv;
    logic [29:0] exp_rpc;
    int   exp_br;
    int   exp_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_taken(input logic [2:0] t, input bit eq, input bit neg, input bit zero);
        case (t)
            3'd1:    return eq;
            3'd2:    return !eq;
            3'd3:    return !neg;
            3'd4:    return !neg && !zero;
            3'd5:    return neg || zero;
            3'd6:    return neg;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, ".redirect_valid"}, redirect_valid, 0);
        chk({tag, ".flush"}, flush, 0);
        chk({tag, ".redirect_pc"}, redirect_pc, 0);
        chk({tag, ".upd_valid"}, upd_valid, 0);
        chk({tag, ".upd_pc"}, upd_pc, 0);
        chk({tag, ".upd_taken"}, upd_taken, 0);
        chk({tag, ".upd_target"}, upd_target, 0);
        chk({tag, ".br_count"}, br_count, 0);
        chk({tag, ".mispred_count"}, mispred_count, 0);
    endtask

    // Checks the queue head before the edge, advances one cycle, then folds the
    // pending resolve into the model and checks redirect and counters.
    task automatic tick();
        chk("upd_valid", upd_valid, 32'(sbq.size() != 0));
        if (sbq.size() != 0) begin
            chk("upd_pc", upd_pc, sbq[0].pc);
            chk("upd_taken", upd_taken, sbq[0].taken);
            chk("upd_target", upd_target, sbq[0].target);
            if (upd_ready) void'(sbq.pop_front());
        end
        @(posedge clk);
        #1;
        if (rst) begin
            sbq.delete();
            exp_rv  = 0;
            exp_rpc = '0;
            exp_br  = 0;
            exp_mis = 0;
        end else begin
            if (pend) begin
                sbq.push_back(pend_rec);
                exp_br++;
            end
            exp_rv = pend && pend_mis;
            if (exp_rv) begin
                exp_rpc = pend_rec.target;
                exp_mis++;
            end
        end
        pend     = 0;
        pend_mis = 0;
        ex_valid = 1'b0;
        chk("redirect_valid", redirect_valid, exp_rv);
        chk("flush", flush, exp_rv);
        if (exp_rv) chk("redirect_pc", redirect_pc, exp_rpc);
        chk("br_count", br_count, exp_br);
        chk("mispred_count", mispred_count, exp_mis);
    endtask

    task automatic drive_br(input logic [2:0] t, input logic [29:0] pc, input logic [15:0] imm,
                            input bit eq, input bit neg, input bit zero, input logic [29:0] pred);
        bit          tk;
        bit          is;
        bit          ok;
        logic [29:0] act;
        ex_valid   = 1'b1;
        ex_type    = t;
        ex_pc      = pc;
        ex_imm     = imm;
        ex_eq      = eq;
        ex_neg     = neg;
        ex_zero    = zero;
        ex_pred_pc = pred;
        tk  = model_taken(t, eq, neg, zero);
        act = tk ? (pc + 30'd1 + {{14{imm[15]}}, imm}) : (pc + 30'd1);
        is  = (t >= 3'd1) && (t <= 3'd6) && !exp_rv;
        ok  = (sbq.size() < 4) || (sbq.size() != 0 && upd_ready);
        #1;
        chk("stall_req", stall_req, 32'(is && !ok));
        if (is && ok) begin
            pend     = 1;
            pend_rec = '{pc: pc, taken: tk, target: act};
            pend_mis = (act != pred);
        end
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_type = '0; ex_pc = '0; ex_imm = '0;
        ex_eq = 1'b0; ex_neg = 1'b0; ex_zero = 1'b0; ex_pred_pc = '0;
        upd_ready = 1'b0;
        pend = 0; pend_mis = 0; pend_rec = '0;
        exp_rv = 0; exp_rpc = '0; exp_br = 0; exp_mis = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // beq taken, mispredicted -> redirect to 0x111
        drive_br(3'd1, 30'h100, 16'h0010, 1, 0, 0, 30'h101);
        tick();
        // mispredicting bne in the redirect cycle is wrong-path
        drive_br(3'd2, 30'h300, 16'h0005, 0, 0, 0, 30'h301);
        tick();
        // bne not taken, correctly predicted
        drive_br(3'd2, 30'h200, 16'h0040, 1, 0, 0, 30'h201);
        tick();
        // bgtz taken with zero offset at the top of the PC space wraps to 0
        drive_br(3'd4, 30'h3FFF_FFFF, 16'h0000, 0, 0, 0, 30'h0);
        tick();
        // blez taken on zero, backward offset, mispredicted
        drive_br(3'd5, 30'h400, 16'hFFFC, 0, 0, 1, 30'h401);
        tick();
        tick();

        // queue full, BHT not ready -> stall, nothing resolves
        drive_br(3'd3, 30'h500, 16'h0002, 0, 0, 0, 30'h503);
        tick();
        drive_br(3'd3, 30'h500, 16'h0002, 0, 0, 0, 30'h503);
        tick();
        // BHT ready -> same branch resolves with a simultaneous pop
        upd_ready = 1'b1;
        drive_br(3'd3, 30'h500, 16'h0002, 0, 0, 0, 30'h503);
        tick();
        // push+pop at full occupancy, large negative offset, mispredicted bltz
        drive_br(3'd6, 30'h600, 16'h8000, 0, 1, 0, 30'h601);
        tick();
        tick();
        // reserved and none types are not branches
        drive_br(3'd7, 30'h650, 16'h0004, 1, 1, 1, 30'h123);
        tick();
        drive_br(3'd0, 30'h660, 16'h0004, 1, 1, 1, 30'h123);
        tick();
        repeat (4) tick();

        // three records queued, then a mispredict resolving under reset
        upd_ready = 1'b0;
        drive_br(3'd1, 30'h700, 16'h0003, 0, 0, 0, 30'h701);
        tick();
        drive_br(3'd1, 30'h710, 16'h0003, 0, 0, 0, 30'h711);
        tick();
        drive_br(3'd3, 30'h720, 16'h0003, 0, 1, 0, 30'h721);
        tick();
        drive_br(3'd1, 30'h730, 16'h0001, 1, 0, 0, 30'h731);
        rst = 1'b1;
        tick();
        check_zero("midreset");
        rst = 1'b0;
        tick();
        check_zero("postreset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
